// File: rtl/axi_lite_master_bridge_pkg.sv
// Shared definitions for the MMU-facing request port and the AXI4-Lite response codes.
package axi_lite_master_bridge_pkg;

  localparam logic MEMREQ_READ  = 1'b0;
  localparam logic MEMREQ_WRITE = 1'b1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // SLVERR and DECERR both become an access fault at the core.
  function automatic logic resp_is_error(input logic [1:0] resp);
    return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
  endfunction

endpackage

// File: rtl/axi_lite_master_bridge_if.sv
// AXI4-Lite channel bundle between the bridge (master) and the memory system (slave).
interface axi_lite_master_bridge_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0]   m_axi_araddr;
  logic                    m_axi_arvalid;
  logic                    m_axi_arready;
  logic [2:0]              m_axi_arprot;

  logic [DATA_WIDTH-1:0]   m_axi_rdata;
  logic [1:0]              m_axi_rresp;
  logic                    m_axi_rvalid;
  logic                    m_axi_rready;

  logic [ADDR_WIDTH-1:0]   m_axi_awaddr;
  logic                    m_axi_awvalid;
  logic                    m_axi_awready;
  logic [2:0]              m_axi_awprot;

  logic [DATA_WIDTH-1:0]   m_axi_wdata;
  logic [DATA_WIDTH/8-1:0] m_axi_wstrb;
  logic                    m_axi_wvalid;
  logic                    m_axi_wready;

  logic [1:0]              m_axi_bresp;
  logic                    m_axi_bvalid;
  logic                    m_axi_bready;

  modport master (
    output m_axi_araddr, m_axi_arvalid, m_axi_arprot,
    input  m_axi_arready,
    input  m_axi_rdata, m_axi_rresp, m_axi_rvalid,
    output m_axi_rready,
    output m_axi_awaddr, m_axi_awvalid, m_axi_awprot,
    input  m_axi_awready,
    output m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
    input  m_axi_wready,
    input  m_axi_bresp, m_axi_bvalid,
    output m_axi_bready
  );

  modport slave (
    input  m_axi_araddr, m_axi_arvalid, m_axi_arprot,
    output m_axi_arready,
    output m_axi_rdata, m_axi_rresp, m_axi_rvalid,
    input  m_axi_rready,
    input  m_axi_awaddr, m_axi_awvalid, m_axi_awprot,
    output m_axi_awready,
    input  m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
    output m_axi_wready,
    output m_axi_bresp, m_axi_bvalid,
    input  m_axi_bready
  );

endinterface

// File: rtl/axi_lite_master_bridge.sv
// Turns one MMU request pulse into exactly one AXI4-Lite read or write and
// reports completion, read data and bus error with a one-cycle response pulse.
module axi_lite_master_bridge
  import axi_lite_master_bridge_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rstn,

  input  logic                    request_enable,
  input  logic                    req_mode,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_wstrb,

  output logic                    response_enable,
  output logic [DATA_WIDTH-1:0]   resp_data,
  output logic                    resp_error,
  output logic                    busy,

  axi_lite_master_bridge_if.master m_axi
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_WR_REQ,
    ST_WR_RESP,
    ST_RESPOND
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
  logic                    arvalid_q, arvalid_d;
  logic                    rready_q, rready_d;
  logic                    awvalid_q, awvalid_d;
  logic                    wvalid_q, wvalid_d;
  logic                    bready_q, bready_d;
  logic                    aw_done_q, aw_done_d;
  logic                    w_done_q, w_done_d;
  logic [DATA_WIDTH-1:0]   resp_data_q, resp_data_d;
  logic                    resp_error_q, resp_error_d;
  logic                    resp_en_q, resp_en_d;
  logic                    aw_hs, w_hs;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    bready_d     = bready_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    resp_data_d  = resp_data_q;
    resp_error_d = resp_error_q;
    resp_en_d    = 1'b0;
    aw_hs        = awvalid_q && m_axi.m_axi_awready;
    w_hs         = wvalid_q && m_axi.m_axi_wready;

    unique case (state_q)
      ST_IDLE: begin
        if (request_enable) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          wstrb_d = req_wstrb;
          if (req_mode == MEMREQ_WRITE) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = ST_WR_REQ;
          end else begin
            arvalid_d = 1'b1;
            state_d   = ST_RD_ADDR;
          end
        end
      end

      ST_RD_ADDR: begin
        if (arvalid_q && m_axi.m_axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_RD_DATA;
        end
      end

      ST_RD_DATA: begin
        if (m_axi.m_axi_rvalid && rready_q) begin
          rready_d     = 1'b0;
          resp_data_d  = m_axi.m_axi_rdata;
          resp_error_d = resp_is_error(m_axi.m_axi_rresp);
          state_d      = ST_RESPOND;
        end
      end

      ST_WR_REQ: begin
        // AW and W complete independently; leave as soon as both are done,
        // including the cycle in which the last of them handshakes.
        if (aw_hs) awvalid_d = 1'b0;
        if (w_hs)  wvalid_d  = 1'b0;
        aw_done_d = aw_done_q || aw_hs;
        w_done_d  = w_done_q || w_hs;
        if (aw_done_d && w_done_d) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          bready_d  = 1'b1;
          state_d   = ST_WR_RESP;
        end
      end

      ST_WR_RESP: begin
        if (m_axi.m_axi_bvalid && bready_q) begin
          bready_d     = 1'b0;
          resp_data_d  = '0;
          resp_error_d = resp_is_error(m_axi.m_axi_bresp);
          state_d      = ST_RESPOND;
        end
      end

      ST_RESPOND: begin
        resp_en_d = 1'b1;
        state_d   = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      resp_data_q  <= '0;
      resp_error_q <= 1'b0;
      resp_en_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      bready_q     <= bready_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
      resp_data_q  <= resp_data_d;
      resp_error_q <= resp_error_d;
      resp_en_q    <= resp_en_d;
    end
  end

  assign response_enable = resp_en_q;
  assign resp_data       = resp_data_q;
  assign resp_error      = resp_error_q;
  assign busy            = (state_q != ST_IDLE);

  assign m_axi.m_axi_araddr  = addr_q;
  assign m_axi.m_axi_arvalid = arvalid_q;
  assign m_axi.m_axi_arprot  = '0;
  assign m_axi.m_axi_rready  = rready_q;
  assign m_axi.m_axi_awaddr  = addr_q;
  assign m_axi.m_axi_awvalid = awvalid_q;
  assign m_axi.m_axi_awprot  = '0;
  assign m_axi.m_axi_wdata   = wdata_q;
  assign m_axi.m_axi_wstrb   = wstrb_q;
  assign m_axi.m_axi_wvalid  = wvalid_q;
  assign m_axi.m_axi_bready  = bready_q;

endmodule

// File: tb/tb_axi_lite_master_bridge.sv
// Randomized bench for the AXI4-Lite master bridge: a delay-configurable slave
// model drives the bus, and each transaction is scored against spec-level expectations.
module tb_axi_lite_master_bridge;
  import axi_lite_master_bridge_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic        request_enable;
  logic        req_mode;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        response_enable;
  logic [31:0] resp_data;
  logic        resp_error;
  logic        busy;

  axi_lite_master_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  axi_lite_master_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .request_enable  (request_enable),
    .req_mode        (req_mode),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .req_wstrb       (req_wstrb),
    .response_enable (response_enable),
    .resp_data       (resp_data),
    .resp_error      (resp_error),
    .busy            (busy),
    .m_axi           (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Slave configuration and observation counters
  int unsigned cfg_ar, cfg_r, cfg_aw, cfg_w, cfg_b;
  logic [31:0] cfg_rdata;
  logic [1:0]  cfg_rresp, cfg_bresp;

  int unsigned n_ar, n_aw, n_w, n_resp, prot_err;
  logic [31:0] obs_araddr, obs_awaddr, obs_wdata;
  logic [3:0]  obs_wstrb;

  // Slave model: acts on the falling edge, judging handshakes from the previous rising edge.
  initial begin : slave_model
    bit          p_arv, p_rr, p_awv, p_wv, p_br;
    logic [31:0] p_araddr, p_awaddr, p_wdata;
    logic [3:0]  p_wstrb;
    bit          ar_hs, r_hs, aw_hs, w_hs, b_hs;
    bit          r_pend, b_pend, aw_got, w_got;
    int unsigned ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
    n_ar = 0; n_aw = 0; n_w = 0; n_resp = 0; prot_err = 0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        bus.m_axi_arready = 1'b0; bus.m_axi_rvalid = 1'b0; bus.m_axi_rdata = '0;
        bus.m_axi_rresp = '0; bus.m_axi_awready = 1'b0; bus.m_axi_wready = 1'b0;
        bus.m_axi_bvalid = 1'b0; bus.m_axi_bresp = '0;
        p_arv = 0; p_rr = 0; p_awv = 0; p_wv = 0; p_br = 0;
        p_araddr = '0; p_awaddr = '0; p_wdata = '0; p_wstrb = '0;
        r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
        ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
      end else begin
        ar_hs = p_arv && bus.m_axi_arready;
        r_hs  = bus.m_axi_rvalid && p_rr;
        aw_hs = p_awv && bus.m_axi_awready;
        w_hs  = p_wv && bus.m_axi_wready;
        b_hs  = bus.m_axi_bvalid && p_br;

        if (ar_hs) begin
          n_ar++; obs_araddr = p_araddr; r_pend = 1; r_cnt = 0;
          if (bus.m_axi_arvalid) prot_err++;
        end else if (p_arv && (!bus.m_axi_arvalid || bus.m_axi_araddr !== p_araddr)) prot_err++;
        if (aw_hs) begin
          n_aw++; obs_awaddr = p_awaddr; aw_got = 1;
          if (bus.m_axi_awvalid) prot_err++;
        end else if (p_awv && (!bus.m_axi_awvalid || bus.m_axi_awaddr !== p_awaddr)) prot_err++;
        if (w_hs) begin
          n_w++; obs_wdata = p_wdata; obs_wstrb = p_wstrb; w_got = 1;
          if (bus.m_axi_wvalid) prot_err++;
        end else if (p_wv && (!bus.m_axi_wvalid || bus.m_axi_wdata !== p_wdata
                              || bus.m_axi_wstrb !== p_wstrb)) prot_err++;
        if (r_hs) begin bus.m_axi_rvalid = 1'b0; if (bus.m_axi_rready) prot_err++; end
        if (b_hs) begin bus.m_axi_bvalid = 1'b0; if (bus.m_axi_bready) prot_err++; end
        if (aw_got && w_got) begin aw_got = 0; w_got = 0; b_pend = 1; b_cnt = 0; end

        bus.m_axi_arready = 1'b0;
        if (bus.m_axi_arvalid && !ar_hs) begin
          if (ar_cnt >= cfg_ar) bus.m_axi_arready = 1'b1; else ar_cnt++;
        end else ar_cnt = 0;
        bus.m_axi_awready = 1'b0;
        if (bus.m_axi_awvalid && !aw_hs) begin
          if (aw_cnt >= cfg_aw) bus.m_axi_awready = 1'b1; else aw_cnt++;
        end else aw_cnt = 0;
        bus.m_axi_wready = 1'b0;
        if (bus.m_axi_wvalid && !w_hs) begin
          if (w_cnt >= cfg_w) bus.m_axi_wready = 1'b1; else w_cnt++;
        end else w_cnt = 0;

        if (r_pend) begin
          if (r_cnt >= cfg_r) begin
            bus.m_axi_rvalid = 1'b1; bus.m_axi_rdata = cfg_rdata;
            bus.m_axi_rresp = cfg_rresp; r_pend = 0;
          end else r_cnt++;
        end
        if (b_pend) begin
          if (b_cnt >= cfg_b) begin
            bus.m_axi_bvalid = 1'b1; bus.m_axi_bresp = cfg_bresp; b_pend = 0;
          end else b_cnt++;
        end

        if (response_enable) n_resp++;
        p_arv = bus.m_axi_arvalid; p_araddr = bus.m_axi_araddr; p_rr = bus.m_axi_rready;
        p_awv = bus.m_axi_awvalid; p_awaddr = bus.m_axi_awaddr;
        p_wv = bus.m_axi_wvalid; p_wdata = bus.m_axi_wdata; p_wstrb = bus.m_axi_wstrb;
        p_br = bus.m_axi_bready;
      end
    end
  end

  // Reference: 4-cycle base latency plus every wait state the slave inserts.
  function automatic int unsigned model_latency(input logic mode, input int unsigned d_ar,
      input int unsigned d_r, input int unsigned d_aw, input int unsigned d_w, input int unsigned d_b);
    if (mode == MEMREQ_WRITE) return 4 + ((d_aw > d_w) ? d_aw : d_w) + d_b;
    return 4 + d_ar + d_r;
  endfunction

  function automatic logic [255:0] all_outputs();
    return {response_enable, resp_data, resp_error, busy,
            bus.m_axi_arvalid, bus.m_axi_araddr, bus.m_axi_arprot, bus.m_axi_rready,
            bus.m_axi_awvalid, bus.m_axi_awaddr, bus.m_axi_awprot,
            bus.m_axi_wvalid, bus.m_axi_wdata, bus.m_axi_wstrb, bus.m_axi_bready};
  endfunction

  task automatic issue(input logic mode, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wstrb);
    @(negedge clk);
    request_enable = 1'b1; req_mode = mode; req_addr = addr; req_wdata = wdata; req_wstrb = wstrb;
    @(negedge clk);
    request_enable = 1'b0;
  endtask

  task automatic run_txn(input string name, input logic mode, input logic [31:0] addr,
      input logic [31:0] wdata, input logic [3:0] wstrb,
      input int unsigned d_ar, input int unsigned d_r, input int unsigned d_aw,
      input int unsigned d_w, input int unsigned d_b,
      input logic [31:0] rdata, input logic [1:0] resp,
      input int unsigned inj, input logic [31:0] inj_addr);
    int unsigned exp_lat, cnt, busy_low, ar0, aw0, w0, resp0, prot0;
    logic [31:0] exp_data, got_data;
    logic        exp_err, got_err, seen;
    cfg_ar = d_ar; cfg_r = d_r; cfg_aw = d_aw; cfg_w = d_w; cfg_b = d_b;
    cfg_rdata = rdata; cfg_rresp = resp; cfg_bresp = resp;
    exp_lat  = model_latency(mode, d_ar, d_r, d_aw, d_w, d_b);
    exp_data = (mode == MEMREQ_WRITE) ? 32'h0 : rdata;
    exp_err  = (resp == RESP_SLVERR) || (resp == RESP_DECERR);
    ar0 = n_ar; aw0 = n_aw; w0 = n_w; resp0 = n_resp; prot0 = prot_err;

    @(negedge clk);
    request_enable = 1'b1; req_mode = mode; req_addr = addr; req_wdata = wdata; req_wstrb = wstrb;
    cnt = 0; busy_low = 0; seen = 1'b0; got_data = '0; got_err = 1'b0;
    while (!seen && cnt < 200) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
      request_enable = (inj != 0) && (cnt == inj);
      if (request_enable) begin
        req_mode = $urandom_range(0, 1); req_addr = inj_addr; req_wdata = $urandom;
      end
      if (response_enable) begin seen = 1'b1; got_data = resp_data; got_err = resp_error; end
      else if (!busy) busy_low++;
    end
    request_enable = 1'b0;
    check_eq({name, "_latency"}, cnt, exp_lat);
    check_eq({name, "_resp_data"}, got_data, exp_data);
    check_eq({name, "_resp_error"}, got_err, exp_err);
    check_eq({name, "_busy_low"}, busy_low, 0);
    repeat (3) @(negedge clk);
    check_eq({name, "_resp_hold"}, {resp_data, resp_error}, {exp_data, exp_err});
    check_eq({name, "_pulses"}, n_resp - resp0, 1);
    check_eq({name, "_protocol"}, prot_err - prot0, 0);
    if (mode == MEMREQ_WRITE) begin
      check_eq({name, "_hs_counts"}, {n_ar - ar0, n_aw - aw0, n_w - w0}, {32'd0, 32'd1, 32'd1});
      check_eq({name, "_aw_beat"}, {obs_awaddr, obs_wdata, obs_wstrb}, {addr, wdata, wstrb});
    end else begin
      check_eq({name, "_hs_counts"}, {n_ar - ar0, n_aw - aw0, n_w - w0}, {32'd1, 32'd0, 32'd0});
      check_eq({name, "_araddr"}, obs_araddr, addr);
    end
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int unsigned resp0, lat, inj, cnt;
    logic        mode;
    logic [1:0]  resp;
    int unsigned d_ar, d_r, d_aw, d_w, d_b;
    rstn = 1'b0; request_enable = 1'b0; req_mode = 1'b0;
    req_addr = '0; req_wdata = '0; req_wstrb = '0;
    cfg_ar = 0; cfg_r = 0; cfg_aw = 0; cfg_w = 0; cfg_b = 0;
    cfg_rdata = '0; cfg_rresp = RESP_OKAY; cfg_bresp = RESP_OKAY;
    repeat (3) @(negedge clk);
    check_eq("reset_outputs", all_outputs(), '0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    run_txn("rd_zero_wait", MEMREQ_READ, 32'h8000_0010, 32'h0, 4'h0,
            0, 0, 0, 0, 0, 32'hDEAD_BEEF, RESP_OKAY, 0, 32'h0);
    run_txn("rd_delayed", MEMREQ_READ, 32'h0000_0444, 32'h0, 4'h0,
            3, 2, 0, 0, 0, 32'hCAFE_F00D, RESP_OKAY, 0, 32'h0);
    run_txn("wr_w_first", MEMREQ_WRITE, 32'h0000_1000, 32'h1234_5678, 4'b0110,
            0, 0, 2, 0, 0, 32'h0, RESP_OKAY, 0, 32'h0);
    run_txn("wr_decerr", MEMREQ_WRITE, 32'h0000_2004, 32'hA5A5_0F0F, 4'b1111,
            0, 0, 0, 0, 0, 32'h0, RESP_DECERR, 0, 32'h0);
    run_txn("rd_slverr", MEMREQ_READ, 32'h0000_3001, 32'h0, 4'h0,
            1, 0, 0, 0, 0, 32'h0BAD_0BAD, RESP_SLVERR, 0, 32'h0);
    run_txn("rd_ignored_req", MEMREQ_READ, 32'h0000_4000, 32'h0, 4'h0,
            0, 4, 0, 0, 0, 32'h1111_2222, RESP_OKAY, 3, 32'h5555_0000);
    run_txn("rd_after_ignored", MEMREQ_READ, 32'h0000_4800, 32'h0, 4'h0,
            0, 0, 0, 0, 0, 32'h3333_4444, RESP_OKAY, 0, 32'h0);

    // Reset while waiting for B: no pulse may follow and the bridge must come back idle.
    cfg_aw = 0; cfg_w = 0; cfg_b = 6; cfg_bresp = RESP_OKAY;
    resp0 = n_resp;
    issue(MEMREQ_WRITE, 32'h0000_5000, 32'hFEED_FACE, 4'b1111);
    cnt = 0;
    while (!bus.m_axi_bready && cnt < 50) begin @(negedge clk); cnt++; end
    check_eq("rst_reached_wr_resp", bus.m_axi_bready, 1'b1);
    rstn = 1'b0;
    @(negedge clk);
    check_eq("rst_mid_outputs", all_outputs(), '0);
    rstn = 1'b1;
    repeat (10) @(negedge clk);
    check_eq("rst_no_pulse", n_resp - resp0, 0);
    check_eq("rst_idle_busy", busy, 1'b0);
    run_txn("rd_after_reset", MEMREQ_READ, 32'h0000_6000, 32'h0, 4'h0,
            0, 0, 0, 0, 0, 32'h7777_8888, RESP_OKAY, 0, 32'h0);

    for (int i = 0; i < 40; i++) begin
      mode = $urandom_range(0, 1);
      resp = $urandom_range(0, 3);
      d_ar = $urandom_range(0, 3); d_r = $urandom_range(0, 3);
      d_aw = $urandom_range(0, 3); d_w = $urandom_range(0, 3); d_b = $urandom_range(0, 3);
      lat = model_latency(mode, d_ar, d_r, d_aw, d_w, d_b);
      inj = ($urandom_range(0, 1) == 1) ? $urandom_range(1, lat - 1) : 0;
      run_txn("rand", mode, $urandom, $urandom, 4'($urandom_range(0, 15)),
              d_ar, d_r, d_aw, d_w, d_b, $urandom, resp, inj, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
